// File: rtl/vec_issue_ctrl.sv
// Scalar-side issue controller: queues vector instructions with their scalar operands,
// issues them one at a time over valid/ready, and returns each ack'd result through a completion register.
module vec_issue_ctrl #(
    parameter int INST_W  = 32,
    parameter int XLEN    = 32,
    parameter int DEPTH   = 4,
    parameter int TIMEOUT = 1024
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              enq_valid,
    output logic              enq_ready,
    input  logic [INST_W-1:0] enq_inst,
    input  logic [XLEN-1:0]   enq_rs1,
    input  logic [XLEN-1:0]   enq_rs2,
    output logic              inst_valid,
    output logic [INST_W-1:0] inst_out,
    output logic [XLEN-1:0]   rs1_out,
    output logic [XLEN-1:0]   rs2_out,
    input  logic              vec_pro_ready,
    input  logic              vec_pro_ack,
    input  logic [XLEN-1:0]   vec_result,
    output logic              scalar_pro_ready,
    output logic              cmpl_valid,
    output logic [XLEN-1:0]   cmpl_data,
    input  logic              cmpl_ready,
    output logic              busy,
    output logic              timeout_err,
    input  logic              timeout_clr
);

    localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int CNT_W = $clog2(DEPTH + 1);
    localparam int WD_W  = (TIMEOUT > 0) ? $clog2(TIMEOUT + 1) : 1;
    localparam int ENT_W = INST_W + 2 * XLEN;

    localparam logic [1:0] S_IDLE     = 2'd0;
    localparam logic [1:0] S_REQ      = 2'd1;
    localparam logic [1:0] S_WAIT_ACK = 2'd2;

    logic [ENT_W-1:0] r_mem [DEPTH];
    logic [PTR_W-1:0] r_wr_ptr;
    logic [PTR_W-1:0] r_rd_ptr;
    logic [CNT_W-1:0] r_count;
    logic [CNT_W-1:0] w_count_nxt;
    logic [1:0]       r_state;
    logic [1:0]       w_state_nxt;
    logic [WD_W-1:0]  r_wdog;
    logic             r_cmpl_valid;
    logic [XLEN-1:0]  r_cmpl_data;
    logic             r_timeout_err;
    logic             w_push;
    logic             w_pop;
    logic             w_cmpl_hs;
    logic             w_wdog_set;

    // Full means full: a same-cycle pop does not open a slot for the push.
    assign enq_ready        = (r_count != CNT_W'(DEPTH));
    assign w_push           = enq_valid && enq_ready;
    assign inst_valid       = (r_state == S_REQ);
    assign w_pop            = inst_valid && vec_pro_ready;
    assign scalar_pro_ready = !r_cmpl_valid || cmpl_ready;
    assign w_cmpl_hs        = (r_state == S_WAIT_ACK) && vec_pro_ack && scalar_pro_ready;
    assign w_count_nxt      = r_count + CNT_W'(w_push) - CNT_W'(w_pop);
    assign w_wdog_set       = (TIMEOUT != 0) && (r_state == S_WAIT_ACK) && !w_cmpl_hs
                              && (r_wdog == WD_W'(TIMEOUT - 1));

    assign {inst_out, rs1_out, rs2_out} = r_mem[r_rd_ptr];
    assign cmpl_valid  = r_cmpl_valid;
    assign cmpl_data   = r_cmpl_data;
    assign timeout_err = r_timeout_err;
    assign busy        = (r_count != '0) || (r_state != S_IDLE);

    // NOTE: the queue storage is reset because the head entry drives outputs directly
    // and those must read zero out of reset; at this depth the cost is a few flops.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            for (int i = 0; i < DEPTH; i++) r_mem[i] <= '0;
        end else if (w_push) begin
            r_mem[r_wr_ptr] <= {enq_inst, enq_rs1, enq_rs2};
        end
    end

    // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
            r_state  <= S_IDLE;
        end else begin
            if (w_push) r_wr_ptr <= r_wr_ptr + PTR_W'(1);
            if (w_pop)  r_rd_ptr <= r_rd_ptr + PTR_W'(1);
            r_count <= w_count_nxt;
            r_state <= w_state_nxt;
        end
    end

    // NOTE: the default assignment up front keeps this block free of inferred latches.
    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            S_IDLE:     if (r_count != '0) w_state_nxt = S_REQ;
            S_REQ:      if (w_pop) w_state_nxt = S_WAIT_ACK;
            S_WAIT_ACK: if (w_cmpl_hs) w_state_nxt = (w_count_nxt != '0) ? S_REQ : S_IDLE;
            default:    w_state_nxt = S_IDLE;
        endcase
    end

    // A fresh load wins over consumption, so consume-and-reload costs no bubble.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_cmpl_valid <= 1'b0;
            r_cmpl_data  <= '0;
        end else if (w_cmpl_hs) begin
            r_cmpl_valid <= 1'b1;
            r_cmpl_data  <= vec_result;
        end else if (r_cmpl_valid && cmpl_ready) begin
            r_cmpl_valid <= 1'b0;
        end
    end

    // Watchdog saturates at TIMEOUT so the sticky error is raised once per wait.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_wdog        <= '0;
            r_timeout_err <= 1'b0;
        end else begin
            if ((r_state != S_WAIT_ACK) || w_cmpl_hs) begin
                r_wdog <= '0;
            end else if ((TIMEOUT != 0) && (r_wdog != WD_W'(TIMEOUT))) begin
                r_wdog <= r_wdog + WD_W'(1);
            end
            if (w_wdog_set) begin
                r_timeout_err <= 1'b1;
            end else if (timeout_clr) begin
                r_timeout_err <= 1'b0;
            end
        end
    end

endmodule

// File: tb/tb_vec_issue_ctrl.sv
// Directed bench for vec_issue_ctrl: inputs change just after the falling edge,
// outputs are checked there, so each rising edge sits between stimulus and check.
module tb_vec_issue_ctrl;

    localparam int INST_W = 32;
    localparam int XLEN   = 32;
    localparam int DEPTH  = 4;
    localparam int TO     = 8;

    logic              clk = 1'b0;
    logic              reset;
    logic              enq_valid;
    logic              enq_ready;
    logic [INST_W-1:0] enq_inst;
    logic [XLEN-1:0]   enq_rs1;
    logic [XLEN-1:0]   enq_rs2;
    logic              inst_valid;
    logic [INST_W-1:0] inst_out;
    logic [XLEN-1:0]   rs1_out;
    logic [XLEN-1:0]   rs2_out;
    logic              vec_pro_ready;
    logic              vec_pro_ack;
    logic [XLEN-1:0]   vec_result;
    logic              scalar_pro_ready;
    logic              cmpl_valid;
    logic [XLEN-1:0]   cmpl_data;
    logic              cmpl_ready;
    logic              busy;
    logic              timeout_err;
    logic              timeout_clr;

    int n_checks = 0;
    int n_errors = 0;

    vec_issue_ctrl #(
        .INST_W (INST_W),
        .XLEN   (XLEN),
        .DEPTH  (DEPTH),
        .TIMEOUT(TO)
    ) dut (
        .clk             (clk),
        .reset           (reset),
        .enq_valid       (enq_valid),
        .enq_ready       (enq_ready),
        .enq_inst        (enq_inst),
        .enq_rs1         (enq_rs1),
        .enq_rs2         (enq_rs2),
        .inst_valid      (inst_valid),
        .inst_out        (inst_out),
        .rs1_out         (rs1_out),
        .rs2_out         (rs2_out),
        .vec_pro_ready   (vec_pro_ready),
        .vec_pro_ack     (vec_pro_ack),
        .vec_result      (vec_result),
        .scalar_pro_ready(scalar_pro_ready),
        .cmpl_valid      (cmpl_valid),
        .cmpl_data       (cmpl_data),
        .cmpl_ready      (cmpl_ready),
        .busy            (busy),
        .timeout_err     (timeout_err),
        .timeout_clr     (timeout_clr)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_checks++;
        assert (obs === exp)
        else begin
            n_errors++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(negedge clk);
    endtask

    // Offer one instruction for exactly one rising edge.
    task automatic enq(input logic [31:0] inst, input logic [31:0] rs1, input logic [31:0] rs2);
        enq_valid = 1'b1;
        enq_inst  = inst;
        enq_rs1   = rs1;
        enq_rs2   = rs2;
        step();
        enq_valid = 1'b0;
    endtask

    // In S_REQ with vec_pro_ready=1: verify the head, then let the handshake happen.
    task automatic issue(input string tag, input logic [31:0] exp_inst);
        check({tag, ".valid"}, inst_valid, 1'b1);
        check({tag, ".inst"}, inst_out, exp_inst);
        step();
        check({tag, ".popped"}, inst_valid, 1'b0);
    endtask

    // In S_WAIT_ACK with room in the completion register: ack for one edge.
    task automatic complete(input string tag, input logic [31:0] res);
        vec_pro_ack = 1'b1;
        vec_result  = res;
        step();
        vec_pro_ack = 1'b0;
        check({tag, ".cvalid"}, cmpl_valid, 1'b1);
        check({tag, ".cdata"}, cmpl_data, res);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "time limit");
    end

    initial begin
        reset = 1'b0; enq_valid = 1'b0; enq_inst = '0; enq_rs1 = '0; enq_rs2 = '0;
        vec_pro_ready = 1'b0; vec_pro_ack = 1'b0; vec_result = '0;
        cmpl_ready = 1'b0; timeout_clr = 1'b0;
        step(); step();

        // Reset values
        check("rst.enq_ready", enq_ready, 1'b1);
        check("rst.spr", scalar_pro_ready, 1'b1);
        check("rst.inst_valid", inst_valid, 1'b0);
        check("rst.inst_out", inst_out, 32'h0);
        check("rst.rs1_out", rs1_out, 32'h0);
        check("rst.cmpl_valid", cmpl_valid, 1'b0);
        check("rst.cmpl_data", cmpl_data, 32'h0);
        check("rst.busy", busy, 1'b0);
        check("rst.timeout_err", timeout_err, 1'b0);
        reset = 1'b1;
        step();

        // Single instruction: valid 2 cycles after enqueue, high exactly one cycle
        vec_pro_ready = 1'b1;
        cmpl_ready    = 1'b1;
        enq(32'h0000_5057, 32'd7, 32'd0);
        check("t1.valid_lat1", inst_valid, 1'b0);
        check("t1.busy", busy, 1'b1);
        step();
        check("t1.rs1", rs1_out, 32'd7);
        issue("t1", 32'h0000_5057);
        step(); step();
        check("t1.wait", inst_valid, 1'b0);
        complete("t1", 32'h10);
        check("t1.busy_fall", busy, 1'b0);
        check("t1.no_reissue", inst_valid, 1'b0);
        step();
        check("t1.consumed", cmpl_valid, 1'b0);

        // Backpressure: request held with stable operands while ready is low
        vec_pro_ready = 1'b0;
        enq(32'h0000_00A1, 32'h11, 32'h22);
        step();
        for (int i = 0; i < 5; i++) begin
            check("t2.hold_valid", inst_valid, 1'b1);
            check("t2.hold_inst", inst_out, 32'h0000_00A1);
            check("t2.hold_rs1", rs1_out, 32'h11);
            check("t2.hold_rs2", rs2_out, 32'h22);
            step();
        end
        check("t2.count_held", dut.r_count, 3'd1);
        vec_pro_ready = 1'b1;
        step();
        check("t2.popped", inst_valid, 1'b0);
        check("t2.count_pop", dut.r_count, 3'd0);
        complete("t2", 32'h55);
        step();

        // Queue full, no bypass on full, push+pop at count 2, order across wrap
        vec_pro_ready = 1'b0;
        enq_valid = 1'b1;
        for (int i = 0; i < 4; i++) begin
            check("t3.ready_before_full", enq_ready, 1'b1);
            enq_inst = 32'h100 + 32'(i);
            step();
        end
        check("t3.full", enq_ready, 1'b0);
        enq_inst = 32'h104;
        step();
        check("t3.fifth_waits", dut.r_count, 3'd4);
        check("t3.head", inst_out, 32'h100);
        vec_pro_ready = 1'b1;
        #1;
        check("t3.no_bypass", enq_ready, 1'b0);
        step();
        check("t3.count_after_pop", dut.r_count, 3'd3);
        check("t3.ready_again", enq_ready, 1'b1);
        step();
        enq_valid = 1'b0;
        check("t3.fifth_in", dut.r_count, 3'd4);
        complete("t3.c0", 32'h1000);
        issue("t3.i1", 32'h101);
        complete("t3.c1", 32'h1001);
        issue("t3.i2", 32'h102);
        complete("t3.c2", 32'h1002);
        check("t3.count2", dut.r_count, 3'd2);
        check("t3.head3", inst_out, 32'h103);
        enq_valid = 1'b1;
        enq_inst  = 32'h105;
        step();
        enq_valid = 1'b0;
        check("t3.pushpop_count", dut.r_count, 3'd2);
        complete("t3.c3", 32'h1003);
        issue("t3.i4_wrap", 32'h104);
        complete("t3.c4", 32'h1004);
        issue("t3.i5", 32'h105);
        complete("t3.c5", 32'h1005);
        check("t3.idle", busy, 1'b0);
        step();

        // Completion stall, then consume-and-reload with zero bubble
        cmpl_ready = 1'b0;
        enq(32'h200, 32'h0, 32'h0);
        enq(32'h201, 32'h0, 32'h0);
        issue("t4.i0", 32'h200);
        complete("t4.c0", 32'h2000);
        issue("t4.i1", 32'h201);
        vec_pro_ack = 1'b1;
        vec_result  = 32'h2001;
        #1;
        check("t4.spr_low", scalar_pro_ready, 1'b0);
        step();
        step();
        check("t4.stall_data", cmpl_data, 32'h2000);
        check("t4.stall_busy", busy, 1'b1);
        check("t4.stall_state", dut.r_state, 2'd2);
        cmpl_ready = 1'b1;
        #1;
        check("t4.spr_high", scalar_pro_ready, 1'b1);
        step();
        vec_pro_ack = 1'b0;
        check("t4.reload_valid", cmpl_valid, 1'b1);
        check("t4.reload_data", cmpl_data, 32'h2001);
        check("t4.idle", busy, 1'b0);
        step();
        check("t4.drained", cmpl_valid, 1'b0);

        // Timeout after 8 WAIT_ACK cycles, sticky, cleared by pulse, later ack completes
        enq(32'h300, 32'h0, 32'h0);
        step();
        issue("t5", 32'h300);
        for (int i = 0; i < TO - 1; i++) step();
        check("t5.before_timeout", timeout_err, 1'b0);
        step();
        check("t5.timeout", timeout_err, 1'b1);
        check("t5.still_waiting", dut.r_state, 2'd2);
        step();
        check("t5.sticky", timeout_err, 1'b1);
        timeout_clr = 1'b1;
        step();
        timeout_clr = 1'b0;
        check("t5.cleared", timeout_err, 1'b0);
        complete("t5", 32'h3000);
        check("t5.err_stays_clear", timeout_err, 1'b0);
        check("t5.idle", busy, 1'b0);
        step();

        // Reset while waiting for an ack with two entries queued
        enq_valid = 1'b1;
        enq_inst  = 32'h400; step();
        enq_inst  = 32'h401; step();
        enq_inst  = 32'h402; step();
        enq_valid = 1'b0;
        check("t6.pre_count", dut.r_count, 3'd2);
        check("t6.pre_wait", dut.r_state, 2'd2);
        #2 reset = 1'b0;
        #1;
        check("t6.rst_busy", busy, 1'b0);
        check("t6.rst_enq_ready", enq_ready, 1'b1);
        check("t6.rst_inst_valid", inst_valid, 1'b0);
        check("t6.rst_inst_out", inst_out, 32'h0);
        check("t6.rst_cmpl_valid", cmpl_valid, 1'b0);
        check("t6.rst_spr", scalar_pro_ready, 1'b1);
        step();
        reset = 1'b1;
        vec_pro_ack = 1'b1;
        vec_result  = 32'hDEAD;
        step(); step();
        check("t6.no_cmpl", cmpl_valid, 1'b0);
        check("t6.no_issue", inst_valid, 1'b0);
        vec_pro_ack = 1'b0;

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule
